// File: rtl/matriz_3x3_loader_if.sv
// Handshake bus between the element producer, the 3x3 loader and the
// determinant consumer. The master side drives elements and out_ready.
interface matriz_3x3_loader_if #(
    parameter int ELEM_W = 8
);
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    logic [ELEM_W-1:0]     in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [9*ELEM_W-1:0]   matriz_3x3;
    logic                  frame_err;

    modport master (
        output clear, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, matriz_3x3, frame_err
    );

    modport slave (
        input  clear, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, matriz_3x3, frame_err
    );
endinterface

// File: rtl/matriz_3x3_loader.sv
// Packs nine row-major elements into one 3x3 matrix word (element a in the
// MSBs) and holds it on a valid/ready output while the next frame assembles.
module matriz_3x3_loader #(
    parameter int ELEM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    matriz_3x3_loader_if.slave bus
);
    logic [3:0]               count;
    logic [7:0][ELEM_W-1:0]   asm_q;
    logic [9*ELEM_W-1:0]      matriz_q;
    logic                     out_valid_q;
    logic                     frame_err_q;
    logic                     in_ready_w;
    logic                     last_slot;
    logic                     beat;
    logic                     bad_frame;
    logic                     complete;

    assign last_slot  = (count == 4'd8);
    // Only the 9th element can collide with an untaken matrix; earlier
    // slots live in the assembly buffer and never stall.
    assign in_ready_w = !(last_slot && out_valid_q && !bus.out_ready);
    assign beat       = bus.in_valid && in_ready_w;
    assign bad_frame  = beat && (bus.in_last != last_slot);
    assign complete   = beat && bus.in_last && last_slot;

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_q;
    assign bus.matriz_3x3 = matriz_q;
    assign bus.frame_err  = frame_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            asm_q       <= '0;
            matriz_q    <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (bus.clear) begin
            count       <= '0;
            asm_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= bad_frame;

            if (bad_frame || complete)
                count <= '0;
            else if (beat)
                count <= count + 4'd1;

            // Slot 0 sits at the top of the packed buffer so the final
            // concatenation lands element a in the MSBs.
            if (beat && !bad_frame && !last_slot)
                asm_q[3'd7 - count[2:0]] <= bus.in_data;

            if (complete) begin
                matriz_q    <= {asm_q, bus.in_data};
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/matriz_3x3_loader.md
Name: matriz_3x3_loader

Overview:
- Serial-to-packed matrix assembler and producer side of the packed 3x3 matrix bus consumed by the determinant datapath.
- Accepts nine signed elements one per valid/ready beat in row-major order and packs them into the 72-bit matrix word, with element a in the MSBs.
- Presents the word on a valid/ready output handshake.
- Double-buffered: assembly of the next matrix overlaps holding of the current one.

Parameters:
- ELEM_W, 8, element width in bits. Packed width is 9*ELEM_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort: discard partial assembly and pending output
- in_valid  input  1  in_data holds a valid element
- in_ready  output  1  loader can accept an element this cycle
- in_data  input  ELEM_W  signed element, row-major order (a,b,c,d,e,f,g,h,i)
- in_last  input  1  marks the 9th element of a frame; qualified by in_valid
- out_valid  output  1  matriz_3x3 holds a complete matrix
- out_ready  input  1  consumer accepts the matrix this cycle
- matriz_3x3  output  9*ELEM_W  packed matrix: a=[9W-1:8W], b=[8W-1:7W], ... i=[W-1:0]
- frame_err  output  1  one-cycle pulse on framing error

Behaviour:
- Reset (async, rst=1):
  - count=0, assembly register=0, matriz_3x3=0.
  - out_valid=0, frame_err=0.
  - in_ready=1 once rst deasserts.
- Input beat: in_valid && in_ready at a rising edge. The element is written to slot count (slot 0 = MSBs). count increments 0..8.
- Framing:
  - in_last must be 1 exactly on the beat with count==8.
  - in_last=1 at count<8, or in_last=0 at count==8: frame_err=1 for the next cycle, the assembly is discarded, count=0, and the output register is untouched.
  - The offending element is consumed, not stored.
- Completion: valid beat at count==8 with in_last=1. The next cycle, matriz_3x3 = {assembly slots 0..7, in_data}, out_valid=1, count=0. Latency from 9th beat to out_valid is 1 cycle.
- in_ready = !(count==8 && out_valid && !out_ready). in_ready is combinational and only stalls the 9th element while an untaken matrix is held.
- Output hold: while out_valid && !out_ready, matriz_3x3 and out_valid stay stable.
- Output handshake:
  - out_valid && out_ready with no completion this cycle: out_valid=0 next cycle. matriz_3x3 keeps its last value.
  - Completion and out handshake in the same cycle: the new matrix loads and out_valid stays 1. Sustained throughput is one matrix per 9 cycles.
- clear (synchronous, priority over all handshakes): next cycle count=0, assembly discarded, out_valid=0, frame_err=0. in_ready is unaffected except through out_valid.
- Element values are stored as raw bits; no sign manipulation.
- Reset mid-frame: all state returns to reset values immediately.

Test Plan:
- Elements 1..9, in_last on 9th, out_ready=1 -> one cycle after 9th beat: out_valid=1, matriz_3x3=72'h010203040506070809; frame_err stays 0.
- Elements -1,2,-3,4,-5,6,-7,8,-9 -> matriz_3x3=72'hFF02FD04FB06F908F7 (signed byte packing check).
- Matrix A held with out_ready=0 while matrix B's 9 elements are streamed -> in_ready=0 only on B's 9th beat; matriz_3x3 stays A. Raise out_ready -> A taken, B loads next cycle.
- in_last on 5th element -> frame_err pulse for one cycle, count=0; next 9 good beats produce the correct matrix.
- Also: 9th beat without in_last -> frame_err pulse, no out_valid.
- clear asserted after 4 elements with out_valid=1 held -> out_valid=0 next cycle; next full frame of 9 elements packs from slot 0.
- Back-to-back frames with out_ready=1, in_valid continuous -> out_valid pulses every 9 cycles, no stall.
- rst asserted mid-frame (count=6) -> outputs immediately 0, and a following frame assembles correctly.
